parity_tx_serializer: RTL and testbench

Upstream transmit stage for the even-parity checking path. It accepts a parallel word over a valid/ready handshake and computes the even parity bit (XOR of all data bits). It then serializes a frame: start bit, data LSB-first, parity bit, stop bit. The receive side deserializes the frame and presents data and parity to the parity checker.

---
 rtl/parity_tx_serializer.sv | 123 ++++++++++++
 tb/tb_parity_tx_serializer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_tx_serializer.sv
// Even-parity transmit serializer: takes a word over valid/ready and sends
// start, data LSB-first, parity and stop bits, each held CLKS_PER_BIT cycles.
//
// state  | meaning
// IDLE   | line high, ready for a word
// START  | start bit (0)
// DATA   | data bits, LSB first
// PARITY | even parity bit
// STOP   | stop bit (1)
module parity_tx_serializer #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             tx_serial,
   output logic             tx_busy,
   output logic             parity_out,
   output logic             frame_done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shift_reg, shift_nxt;
   logic [CNT_W-1:0] cyc_cnt, cyc_nxt;
   logic [BIT_W-1:0] bit_cnt, bit_nxt;
   logic             parity_nxt;
   logic             serial_nxt;
   logic             busy_nxt;
   logic             done_nxt;
   logic             bit_end;

   assign data_ready = (state == IDLE) && !rst;
   assign bit_end    = (cyc_cnt == CYC_LAST);

   always_comb begin
      state_nxt  = state;
      shift_nxt  = shift_reg;
      parity_nxt = parity_out;
      cyc_nxt    = cyc_cnt;
      bit_nxt    = bit_cnt;

      if (state != IDLE) begin
         cyc_nxt = bit_end ? '0 : cyc_cnt + CNT_W'(1);
      end

      case (state)
         IDLE: begin
            if (data_valid && data_ready) begin
               state_nxt  = START;
               shift_nxt  = data_in;
               parity_nxt = ^data_in;
               cyc_nxt    = '0;
               bit_nxt    = '0;
            end
         end
         START: begin
            if (bit_end) state_nxt = DATA;
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt == BIT_LAST) begin
                  state_nxt = PARITY;
                  bit_nxt   = '0;
               end else begin
                  bit_nxt   = bit_cnt + BIT_W'(1);
                  shift_nxt = shift_reg >> 1;
               end
            end
         end
         PARITY: begin
            if (bit_end) state_nxt = STOP;
         end
         STOP: begin
            if (bit_end) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Line outputs are registered from the upcoming state so the start bit
      // appears on the cycle right after the accept edge.
      case (state_nxt)
         START:   serial_nxt = 1'b0;
         DATA:    serial_nxt = shift_nxt[0];
         PARITY:  serial_nxt = parity_nxt;
         default: serial_nxt = 1'b1;
      endcase
      busy_nxt = (state_nxt != IDLE);
      done_nxt = (state == STOP) && (state_nxt == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         shift_reg  <= '0;
         cyc_cnt    <= '0;
         bit_cnt    <= '0;
         parity_out <= 1'b0;
         tx_serial  <= 1'b1;
         tx_busy    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         shift_reg  <= shift_nxt;
         cyc_cnt    <= cyc_nxt;
         bit_cnt    <= bit_nxt;
         parity_out <= parity_nxt;
         tx_serial  <= serial_nxt;
         tx_busy    <= busy_nxt;
         frame_done <= done_nxt;
      end
   end

endmodule

// File: tb/tb_parity_tx_serializer.sv
// Bench for parity_tx_serializer: 8-bit/4-clk instance checked by a frame
// scoreboard and loopback receiver, plus a 4-bit/1-clk instance.
module tb_parity_tx_serializer;

   localparam int W   = 8;
   localparam int CPB = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] data_in;
   logic         data_valid;
   logic         data_ready, tx_serial, tx_busy, parity_out, frame_done;

   logic [3:0]   s_data;
   logic         s_valid;
   logic         s_ready, s_serial, s_busy, s_parity, s_done;

   always #5 clk = ~clk;

   parity_tx_serializer #(.WIDTH(W), .CLKS_PER_BIT(CPB)) u_dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
      .data_ready(data_ready), .tx_serial(tx_serial), .tx_busy(tx_busy),
      .parity_out(parity_out), .frame_done(frame_done)
   );

   parity_tx_serializer #(.WIDTH(4), .CLKS_PER_BIT(1)) u_dut_small (
      .clk(clk), .rst(rst), .data_in(s_data), .data_valid(s_valid),
      .data_ready(s_ready), .tx_serial(s_serial), .tx_busy(s_busy),
      .parity_out(s_parity), .frame_done(s_done)
   );

   typedef struct {
      logic [W-1:0] word;
      logic         par;
      int           acc_cyc;
   } exp_t;

   exp_t   sb_q[$];
   exp_t   cur;
   int     done_t[$];
   int     cyc = 0;
   int     n_tests = 0;
   int     n_fail = 0;
   bit     mon_active = 0;
   bit     exp_done = 0;
   int     mon_idx = 0;
   logic [W-1:0] rx_word;
   logic         rx_par;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Frame monitor / loopback receiver
   always @(negedge clk) begin
      int   slot;
      logic exp_bit;
      if (rst) begin
         mon_active = 0;
         exp_done   = 0;
      end else begin
         if (exp_done) begin
            chk("frame_done", frame_done, 1);
            chk("done_busy", tx_busy, 0);
            chk("done_serial", tx_serial, 1);
            done_t.push_back(cyc);
            exp_done = 0;
         end else if (frame_done === 1'b1) begin
            chk("spurious_done", frame_done, 0);
         end
         if (!mon_active && tx_busy === 1'b1) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_frame", tx_busy, 0);
            end else begin
               cur = sb_q.pop_front();
               chk("latency", cyc, cur.acc_cyc);
               mon_active = 1;
               mon_idx    = 0;
            end
         end
         if (mon_active) begin
            slot = mon_idx / CPB;
            if (slot == 0)           exp_bit = 1'b0;
            else if (slot <= W)      exp_bit = cur.word[slot-1];
            else if (slot == W + 1)  exp_bit = cur.par;
            else                     exp_bit = 1'b1;
            chk("tx_serial", tx_serial, exp_bit);
            chk("tx_busy", tx_busy, 1);
            chk("parity_out", parity_out, cur.par);
            if (mon_idx % CPB == 0) begin
               if (slot >= 1 && slot <= W) rx_word[slot-1] = tx_serial;
               if (slot == W + 1)          rx_par = tx_serial;
            end
            mon_idx++;
            if (mon_idx == (W + 3) * CPB) begin
               mon_active = 0;
               exp_done   = 1;
               chk("rx_data", rx_word, cur.word);
               chk("rx_error_flag", ^rx_word ^ rx_par, 0);
            end
         end
      end
   end

   task automatic send(input logic [W-1:0] word, input logic par, input bit drop);
      bit acc_ok;
      exp_t e;
      acc_ok = 0;
      @(posedge clk); #1;
      data_in    = word;
      data_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (data_ready === 1'b1) begin
            e.word    = word;
            e.par     = par;
            e.acc_cyc = cyc + 1;
            sb_q.push_back(e);
            acc_ok = 1;
            break;
         end
      end
      chk("accept_timeout", acc_ok, 1);
      @(posedge clk); #1;
      if (drop) data_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit idle_ok;
      idle_ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         if (sb_q.size() == 0 && !mon_active && !exp_done && tx_busy === 1'b0) begin
            idle_ok = 1;
            break;
         end
      end
      chk("idle_timeout", idle_ok, 1);
   endtask

   initial begin
      logic [6:0] pat;
      rst        = 1'b1;
      data_in    = 8'h5A;
      data_valid = 1'b1;
      s_data     = 4'h0;
      s_valid    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_serial", tx_serial, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_parity", parity_out, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_ready", data_ready, 0);
      chk("rst_small_ready", s_ready, 0);
      @(posedge clk); #1;
      rst        = 1'b0;
      data_valid = 1'b0;
      @(negedge clk);
      chk("idle_ready", data_ready, 1);
      chk("idle_busy", tx_busy, 0);

      send(8'hA5, 1'b0, 1);
      wait_idle();
      send(8'h07, 1'b1, 1);
      wait_idle();

      done_t.delete();
      send(8'h3C, 1'b0, 0);
      send(8'hFF, 1'b0, 1);
      wait_idle();
      chk("b2b_pulses", done_t.size(), 2);
      if (done_t.size() == 2) chk("b2b_gap", done_t[1] - done_t[0], 45);

      send(8'h81, 1'b0, 1);
      repeat (12) @(posedge clk);
      #1;
      data_in    = 8'h55;
      data_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("ready_while_busy", data_ready, 0);
      end
      @(posedge clk); #1;
      data_valid = 1'b0;
      wait_idle();

      send(8'hF0, 1'b0, 1);
      repeat (12) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("ready_in_rst", data_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_serial", tx_serial, 1);
      chk("abort_busy", tx_busy, 0);
      chk("abort_done", frame_done, 0);
      chk("abort_parity", parity_out, 0);
      repeat (60) @(negedge clk) begin
         chk("abort_no_resume", tx_busy, 0);
      end
      send(8'h01, 1'b1, 1);
      wait_idle();

      pat = 7'b1110110;
      @(posedge clk); #1;
      s_data  = 4'hB;
      s_valid = 1'b1;
      @(negedge clk);
      chk("small_ready", s_ready, 1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("small_serial", s_serial, pat[i]);
         chk("small_busy", s_busy, 1);
         chk("small_done_early", s_done, 0);
         chk("small_parity", s_parity, 1);
      end
      @(negedge clk);
      chk("small_done", s_done, 1);
      chk("small_idle_serial", s_serial, 1);
      chk("small_idle_busy", s_busy, 0);
      @(negedge clk);
      chk("small_done_pulse", s_done, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
